// File: rtl/misaligned_lsu.sv
// misaligned_lsu: MEM-stage load/store sequencer in front of the data memory.
// Word-crossing accesses are split into naturally aligned beats. Loads are
// always fetched as whole words and the lane is selected and extended here.
module misaligned_lsu #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  MemRead_i,
    input  logic                  MemWrite_i,
    input  logic [2:0]            Funct3_i,
    input  logic [DM_ADDRESS-1:0] addr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    output logic [DATA_W-1:0]     rdata_o,
    output logic                  stall_o,
    output logic                  MemRead_o,
    output logic                  MemWrite_o,
    output logic [2:0]            Funct3_o,
    output logic [DM_ADDRESS-1:0] a_o,
    output logic [DATA_W-1:0]     wd_o,
    input  logic [DATA_W-1:0]     rd_i,
    output logic [15:0]           split_cnt_o
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SPLIT = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [1:0]              beat_q, beat_d;
    logic [DATA_W-1:0]       hold_q, hold_d;
    logic [15:0]             split_cnt_q, split_cnt_d;

    logic                    is_load, is_store, active, sw_word, last;
    logic [2:0]              size, span, n_beats;
    logic [1:0]              cur_beat;
    logic [DM_ADDRESS-3:0]   word_idx;
    logic [DATA_W-1:0]       w0;

    // Shift the two-word window down to the addressed byte, then extend.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [2*DATA_W-1:0] pair,
        input logic [1:0]          off,
        input logic [2:0]          f3
    );
        logic [2*DATA_W-1:0] s;
        s = pair >> {off, 3'b000};
        case (f3)
            3'b000:  load_extend = {{(DATA_W-8){s[7]}}, s[7:0]};
            3'b001:  load_extend = {{(DATA_W-16){s[15]}}, s[15:0]};
            3'b100:  load_extend = {{(DATA_W-8){1'b0}}, s[7:0]};
            3'b101:  load_extend = {{(DATA_W-16){1'b0}}, s[15:0]};
            default: load_extend = s[DATA_W-1:0];
        endcase
    endfunction

    // Decode the request: access size, beat count and the beat being issued now.
    always_comb begin
        is_load  = MemRead_i;
        is_store = MemWrite_i & ~MemRead_i;
        active   = reset_n & (is_load | is_store);
        case (Funct3_i[1:0])
            2'b00:   size = 3'd1;
            2'b01:   size = 3'd2;
            default: size = 3'd4;   // W, and undefined encodings sized as W
        endcase
        span    = {1'b0, addr_i[1:0]} + size;
        sw_word = (size == 3'd4) && (addr_i[1:0] == 2'b00);
        if (is_load) begin
            n_beats = (span > 3'd4) ? 3'd2 : 3'd1;
        end else if (size == 3'd4) begin
            n_beats = sw_word ? 3'd1 : 3'd4;
        end else begin
            n_beats = size;
        end
        cur_beat = (state_q == S_SPLIT) ? beat_q : 2'd0;
        last     = ({1'b0, cur_beat} == (n_beats - 3'd1));
        word_idx = addr_i[DM_ADDRESS-1:2] + (DM_ADDRESS-2)'(cur_beat[0]);
    end

    // Drive the memory port and the pipeline-facing outputs for the current beat.
    always_comb begin
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        Funct3_o   = 3'b000;
        a_o        = '0;
        wd_o       = '0;
        stall_o    = 1'b0;
        rdata_o    = '0;
        w0         = (state_q == S_SPLIT) ? hold_q : rd_i;
        if (active) begin
            stall_o = ~last;
            if (is_load) begin
                MemRead_o = 1'b1;
                Funct3_o  = 3'b010;
                a_o       = {word_idx, 2'b00};
                if (last) begin
                    rdata_o = load_extend({rd_i, w0}, addr_i[1:0], Funct3_i);
                end
            end else begin
                MemWrite_o = 1'b1;
                if (sw_word) begin
                    Funct3_o = 3'b010;
                    a_o      = addr_i;
                    wd_o     = wdata_i;
                end else begin
                    Funct3_o = 3'b000;
                    a_o      = addr_i + DM_ADDRESS'(cur_beat);
                    wd_o     = {{(DATA_W-8){1'b0}}, wdata_i[{cur_beat, 3'b000} +: 8]};
                end
            end
        end
    end

    // Next-state for the beat sequencer, first-word capture and split counter.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        hold_d      = hold_q;
        split_cnt_d = split_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (active && !last) begin
                    state_d = S_SPLIT;
                    beat_d  = 2'd1;
                    if (is_load) begin
                        hold_d = rd_i;
                    end
                    if (split_cnt_q != 16'hFFFF) begin
                        split_cnt_d = split_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                // A vanished request cannot be finished; fall back to IDLE.
                if (!active || last) begin
                    state_d = S_IDLE;
                    beat_d  = 2'd0;
                end else begin
                    beat_d = beat_q + 2'd1;
                end
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            beat_q      <= 2'd0;
            hold_q      <= '0;
            split_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            hold_q      <= hold_d;
            split_cnt_q <= split_cnt_d;
        end
    end

    assign split_cnt_o = split_cnt_q;

endmodule

// File: tb/tb_misaligned_lsu.sv
// tb_misaligned_lsu: directed bench for misaligned_lsu with a byte-array data memory.
module tb_misaligned_lsu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MemRead_i, MemWrite_i;
    logic [2:0]  Funct3_i;
    logic [8:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o, MemRead_o, MemWrite_o;
    logic [2:0]  Funct3_o;
    logic [8:0]  a_o;
    logic [31:0] wd_o, rd_i;
    logic [15:0] split_cnt_o;

    logic [7:0]  mem [0:511];
    logic        preload;

    int checks = 0;
    int errors = 0;

    logic [8:0]  beat_a [$];
    logic [2:0]  beat_f [$];
    logic [31:0] beat_w [$];
    logic        rd_nz;
    int          cyc, st;
    logic [31:0] rdat;

    misaligned_lsu #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i), .Funct3_i(Funct3_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .rdata_o(rdata_o), .stall_o(stall_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .Funct3_o(Funct3_o),
        .a_o(a_o), .wd_o(wd_o), .rd_i(rd_i), .split_cnt_o(split_cnt_o)
    );

    always #5 clk = ~clk;

    // Read data is combinational from the word containing a_o.
    assign rd_i = {mem[{a_o[8:2], 2'b11}], mem[{a_o[8:2], 2'b10}],
                   mem[{a_o[8:2], 2'b01}], mem[{a_o[8:2], 2'b00}]};

    // Data memory: preload on the first edge, then apply SW/SB writes.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
            mem[9'h08] <= 8'hAA; mem[9'h09] <= 8'hBB; mem[9'h0A] <= 8'hCC; mem[9'h0B] <= 8'hDD;
            mem[9'h0C] <= 8'h11; mem[9'h0D] <= 8'h22; mem[9'h0E] <= 8'h33; mem[9'h0F] <= 8'h44;
        end else if (MemWrite_o) begin
            if (Funct3_o == 3'b010) begin
                for (int k = 0; k < 4; k++) mem[a_o + 9'(k)] <= wd_o[8*k +: 8];
            end else begin
                mem[a_o] <= wd_o[7:0];
            end
        end
    end

    // Pipeline must hold the request steady while stalled.
    a_req_stable: assert property (@(posedge clk) disable iff (!reset_n)
        stall_o |=> $stable({MemRead_i, MemWrite_i, Funct3_i, addr_i, wdata_i}));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=0x%08h exp=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [8:0] a);
        return {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]};
    endfunction

    // Present one request and run it to completion (bounded), logging each beat.
    task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [8:0] ad, input logic [31:0] wd);
        logic done;
        beat_a.delete(); beat_f.delete(); beat_w.delete();
        rd_nz = 1'b0; cyc = 0; st = 0; rdat = 32'h0; done = 1'b0;
        MemRead_i = rd; MemWrite_i = wr; Funct3_i = f3; addr_i = ad; wdata_i = wd;
        while (!done && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (MemRead_o || MemWrite_o) begin
                beat_a.push_back(a_o); beat_f.push_back(Funct3_o); beat_w.push_back(wd_o);
            end
            if (stall_o) begin
                st++;
                if (rdata_o != 32'h0) rd_nz = 1'b1;
            end else begin
                rdat = rdata_o;
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) chk("req_timeout", 32'(cyc), 32'd0);
        MemRead_i = 1'b0; MemWrite_i = 1'b0; Funct3_i = 3'b000; addr_i = '0; wdata_i = '0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        preload = 1'b1;
        reset_n = 1'b0;
        MemRead_i = 1'b1; MemWrite_i = 1'b0; Funct3_i = 3'b010; addr_i = 9'h0A; wdata_i = '0;
        @(posedge clk); #1;
        preload = 1'b0;
        // Outputs must be quiet while reset_n is low, even with a request pending.
        @(negedge clk);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_memread", 32'(MemRead_o), 32'd0);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_cnt", 32'(split_cnt_o), 32'd0);
        @(posedge clk); #1;
        MemRead_i = 1'b0;
        reset_n = 1'b1;

        req(1, 0, 3'b010, 9'h08, 0);
        chk("lw08_cyc", 32'(cyc), 1); chk("lw08_stall", 32'(st), 0);
        chk("lw08_data", rdat, 32'hDDCCBBAA);
        chk("lw08_beats", 32'(beat_a.size()), 1);
        if (beat_a.size() >= 1) begin
            chk("lw08_addr", 32'(beat_a[0]), 32'h08); chk("lw08_f3", 32'(beat_f[0]), 32'd2);
        end

        req(1, 0, 3'b001, 9'h0A, 0); chk("lh0a", rdat, 32'hFFFFDDCC); chk("lh0a_stall", 32'(st), 0);
        req(1, 0, 3'b101, 9'h0A, 0); chk("lhu0a", rdat, 32'h0000DDCC);
        req(1, 0, 3'b100, 9'h0B, 0); chk("lbu0b", rdat, 32'h000000DD);
        req(1, 0, 3'b000, 9'h09, 0); chk("lb09", rdat, 32'hFFFFFFBB);

        req(1, 0, 3'b010, 9'h0A, 0);
        chk("lw0a_cyc", 32'(cyc), 2); chk("lw0a_stall", 32'(st), 1);
        chk("lw0a_data", rdat, 32'h2211DDCC); chk("lw0a_rdz", 32'(rd_nz), 0);
        chk("lw0a_beats", 32'(beat_a.size()), 2);
        if (beat_a.size() >= 2) begin
            chk("lw0a_a0", 32'(beat_a[0]), 32'h08); chk("lw0a_a1", 32'(beat_a[1]), 32'h0C);
            chk("lw0a_f3", 32'(beat_f[1]), 32'd2);
        end
        req(1, 0, 3'b001, 9'h0B, 0);
        chk("lh0b", rdat, 32'h000011DD); chk("lh0b_stall", 32'(st), 1);
        chk("cnt_two", 32'(split_cnt_o), 32'd2);

        do_reset();
        chk("cnt_cleared", 32'(split_cnt_o), 32'd0);
        req(0, 1, 3'b010, 9'h1FE, 32'h12345678);
        chk("sw1fe_cyc", 32'(cyc), 4); chk("sw1fe_stall", 32'(st), 3);
        chk("sw1fe_beats", 32'(beat_a.size()), 4);
        if (beat_a.size() >= 4) begin
            chk("sw1fe_a0", 32'(beat_a[0]), 32'h1FE); chk("sw1fe_a1", 32'(beat_a[1]), 32'h1FF);
            chk("sw1fe_a2", 32'(beat_a[2]), 32'h000); chk("sw1fe_a3", 32'(beat_a[3]), 32'h001);
            chk("sw1fe_f3", 32'(beat_f[2]), 32'd0);
            chk("sw1fe_wd0", beat_w[0], 32'h00000078); chk("sw1fe_wd3", beat_w[3], 32'h00000012);
        end
        chk("m1fe", 32'(mem[9'h1FE]), 32'h78); chk("m1ff", 32'(mem[9'h1FF]), 32'h56);
        chk("m000", 32'(mem[9'h000]), 32'h34); chk("m001", 32'(mem[9'h001]), 32'h12);
        chk("cnt_one", 32'(split_cnt_o), 32'd1);
        req(1, 0, 3'b010, 9'h1FE, 0); chk("lw1fe_wrap", rdat, 32'h12345678);

        req(0, 1, 3'b001, 9'h0A, 32'h0000BEEF);
        chk("sh0a_beats", 32'(beat_a.size()), 2); chk("sh0a_stall", 32'(st), 1);
        req(1, 0, 3'b010, 9'h08, 0); chk("sh0a_w08", rdat, 32'hBEEFBBAA);
        req(1, 0, 3'b010, 9'h0C, 0); chk("sh0a_w0c", rdat, 32'h44332211);

        req(0, 1, 3'b010, 9'h10, 32'hCAFEF00D);
        chk("sw10_beats", 32'(beat_a.size()), 1); chk("sw10_stall", 32'(st), 0);
        if (beat_f.size() >= 1) chk("sw10_f3", 32'(beat_f[0]), 32'd2);
        chk("sw10_mem", mem_word(9'h10), 32'hCAFEF00D);

        req(1, 1, 3'b010, 9'h10, 32'hFFFFFFFF);
        chk("rdwr_data", rdat, 32'hCAFEF00D); chk("rdwr_nowrite", mem_word(9'h10), 32'hCAFEF00D);

        // Misaligned SW at 0x05 interrupted by reset during beat 2.
        MemWrite_i = 1'b1; Funct3_i = 3'b010; addr_i = 9'h05; wdata_i = 32'hA1B2C3D4;
        @(negedge clk);
        chk("abort_b0_stall", 32'(stall_o), 32'd1); chk("abort_b0_a", 32'(a_o), 32'h05);
        @(posedge clk); #1;
        @(negedge clk);
        chk("abort_b1_a", 32'(a_o), 32'h06); chk("abort_b1_we", 32'(MemWrite_o), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(negedge clk);
        chk("abort_rst_we", 32'(MemWrite_o), 32'd0); chk("abort_rst_stall", 32'(stall_o), 32'd0);
        chk("abort_rst_re", 32'(MemRead_o), 32'd0); chk("abort_rst_rd", rdata_o, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        MemWrite_i = 1'b0; Funct3_i = 3'b000; addr_i = '0; wdata_i = '0;
        @(negedge clk);
        chk("abort_idle_stall", 32'(stall_o), 32'd0); chk("abort_cnt", 32'(split_cnt_o), 32'd0);
        chk("abort_m05", 32'(mem[9'h05]), 32'hD4); chk("abort_m06", 32'(mem[9'h06]), 32'hC3);
        chk("abort_m07", 32'(mem[9'h07]), 32'h00);
        @(posedge clk); #1;
        req(1, 0, 3'b010, 9'h08, 0); chk("abort_w08", rdat, 32'hBEEFBBAA);
        chk("abort_w08_stall", 32'(st), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/misaligned_lsu.md
# misaligned_lsu

Load/store sequencer that sits in the MEM stage directly upstream of the data memory: it takes the pipeline's memory request (MemRead/MemWrite, Funct3, byte address, store data) and issues it to the data memory as one or more naturally aligned beats. It splits word-crossing accesses into multiple beats and assembles load results with sign/zero extension. It stalls the pipeline while a multi-beat access is in flight.

## Interface
- DM_ADDRESS, 9, byte-address width into data memory
- DATA_W, 32, data width
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- MemRead_i  in  1  load request from control unit
- MemWrite_i  in  1  store request from control unit
- Funct3_i  in  3  instruction bits 14:12 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- addr_i  in  DM_ADDRESS  byte address (ALU result LSBs)
- wdata_i  in  DATA_W  store data (rs2)
- rdata_o  out  DATA_W  extended load result
- stall_o  out  1  pipeline hold; request inputs must remain stable while high
- MemRead_o, MemWrite_o  out  1 each  to data memory
- Funct3_o  out  3  to data memory; only 010 (LW/SW) or 000 (SB) is ever driven
- a_o  out  DM_ADDRESS  to data memory
- wd_o  out  DATA_W  to data memory
- rd_i  in  DATA_W  read data from data memory, valid in the same cycle the read address is presented
- split_cnt_o  out  16  saturating count of multi-beat requests accepted

## Operation
- All loads are issued as LW at word address {a[8:2],2'b00}; lane selection and extension are done here. LB/LBU/LH/LHU/LW are never issued in byte or halfword form.
- Stores are issued as SW when addr_i[1:0]==00 and Funct3 is W. All other stores are issued as SB beats at consecutive byte addresses, with wd_o={24'b0,byte}.
- MemRead_i and MemWrite_i both high: treated as a load; the write is ignored.
- Beat count N:
  - loads: 2 if addr[1:0] + size > 4 (H at 11; W at 01/10/11), else 1
  - SB = 1; SH = 2; SW aligned = 1; SW misaligned = 4
- Load assembly: w0 = first word, w1 = second word (w1 = w0 when N=1). Form {w1,w0} >> 8*addr[1:0] and take bits [7:0], [15:0] or [31:0].
  - Sign-extend for 000/001; zero-extend for 100/101; 010 is passed as-is.
- Store beat i writes byte wdata_i[8i+7:8i] to address addr_i+i (little-endian).
- Address arithmetic is modulo 2^DM_ADDRESS; wrap from 0x1FF to 0x000 is legal.
- Load word index +1 wraps from 127 to 0.
- FSM:
  - IDLE: a request with N=1 is issued combinationally and completes in the same cycle; stall_o=0.
  - IDLE: a request with N>1 issues beat 0, asserts stall_o, sets beat=1 and goes to SPLIT. For loads, rd_i is captured into hold_q at the clock edge.
  - SPLIT: issue beat `beat`. If beat==N-1, deassert stall_o (loads present rdata_o from hold_q and live rd_i), then go to IDLE. Otherwise beat++.
- split_cnt_o increments on each IDLE to SPLIT transition and saturates at 0xFFFF.
- Undefined Funct3 (011, 110, 111): handled as W for sizing and extension.

## Timing
- Latency: N cycles. A 1-beat access has zero added latency. stall_o is high for exactly N-1 cycles per request.
- rdata_o is valid only in the completing cycle and is 0 otherwise.
- MemRead_o/MemWrite_o are high only in cycles where a beat is issued.
- Reset (reset_n low at a clock edge):
  - state=IDLE, beat=0, hold_q=0, split_cnt_o=0.
  - Combinational outputs while reset_n is low: stall_o=0, MemRead_o=0, MemWrite_o=0, rdata_o=0.
- Reset mid-SPLIT aborts the access. Store beats already issued remain in memory; no further beats are issued.
- A new request is sampled only in IDLE. Changes to the inputs during SPLIT are a pipeline protocol violation; the bench asserts against them.

## Test plan
Memory is preloaded with word 0x08=0xDDCCBBAA and word 0x0C=0x44332211.
- LW addr 0x08 -> 1 cycle, stall_o never high, rdata_o=0xDDCCBBAA, one LW at a_o=0x08.
- LH addr 0x0A -> 1 cycle, rdata_o=0xFFFFDDCC. LHU addr 0x0A -> rdata_o=0x0000DDCC. LBU addr 0x0B -> 0x000000DD.
- LW addr 0x0A -> stall_o high 1 cycle, LW at 0x08 then at 0x0C, rdata_o=0x2211DDCC in cycle 2. LH addr 0x0B -> 0x000011DD.
- SW 0x12345678 at addr 0x1FE -> 4 SB beats, stall_o high 3 cycles. Afterwards bytes 0x1FE=0x78, 0x1FF=0x56, 0x000=0x34, 0x001=0x12, and split_cnt_o=1.
- SH 0xBEEF at addr 0x0A -> 2 SB beats. Word 0x08 reads back 0xBEEFBBAA; word 0x0C is unchanged.
- SW misaligned at 0x05, with reset_n low during beat 2 -> state returns to IDLE. Bytes 0x05 and 0x06 are written, byte 0x07 and word 0x08 are untouched, and all outputs are 0 during reset.
